// File: rtl/alu_arbiter.sv
// alu_arbiter: sequencer and two-port round-robin arbiter for a shared,
// purely combinational N-bit ALU (AND/OR/ADD/SUB).
//
// Flow: IDLE (grant one requester, latch its op) -> EXEC (ALU inputs come
// from registers; result and carry are captured at the end of the cycle)
// -> RESP (registered response is held until the consumer takes it).
// Accept in cycle t, response valid from t+2, next accept possible in t+3.
//
// Ports:
//   clk_i, rst_n_i                 clock (rising edge), async active-low reset
//   req0_* / req1_*                requester valid/ready/op/operands
//   rsp_valid_o, rsp_ready_i       back-pressured response handshake
//   rsp_result_o, rsp_carry_o      registered ALU result and carry
//   rsp_id_o                       requester that issued the op
//   alu_control_o, alu_a_o/b_o     registered drive to the ALU
//   alu_result_i, alu_carry_i      ALU outputs
//   busy_o                         high whenever the FSM is not in IDLE
//
// Build option: ALU_ARB_FIXED_PRIO_EN
//   defined   -> requester 0 always wins contention (last_id still tracked)
//   undefined -> round-robin on contention (default)

module alu_arbiter #(
  parameter int N = 64
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         req0_valid_i,
  output logic         req0_ready_o,
  input  logic [1:0]   req0_op_i,
  input  logic [N-1:0] req0_a_i,
  input  logic [N-1:0] req0_b_i,
  input  logic         req1_valid_i,
  output logic         req1_ready_o,
  input  logic [1:0]   req1_op_i,
  input  logic [N-1:0] req1_a_i,
  input  logic [N-1:0] req1_b_i,
  output logic         rsp_valid_o,
  input  logic         rsp_ready_i,
  output logic [N-1:0] rsp_result_o,
  output logic         rsp_carry_o,
  output logic         rsp_id_o,
  output logic [1:0]   alu_control_o,
  output logic [N-1:0] alu_a_o,
  output logic [N-1:0] alu_b_o,
  input  logic [N-1:0] alu_result_i,
  input  logic         alu_carry_i,
  output logic         busy_o
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_t;

  state_t         state_r;
  state_t         state_next_s;
  logic           gnt0_s;
  logic           gnt1_s;
  logic           last_id_r;
  logic [1:0]     op_r;
  logic [N-1:0]   a_r;
  logic [N-1:0]   b_r;
  logic           id_r;
  logic [N-1:0]   result_r;
  logic           carry_r;

  // Grant selection; only IDLE may grant, so readies never depend on rsp_ready_i
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (state_r == IDLE) begin
      if (req0_valid_i && req1_valid_i) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
        gnt0_s = 1'b1;
`else
        // last_id resets to 1, so requester 0 wins the first contention
        if (last_id_r) begin
          gnt0_s = 1'b1;
        end else begin
          gnt1_s = 1'b1;
        end
`endif
      end else if (req0_valid_i) begin
        gnt0_s = 1'b1;
      end else if (req1_valid_i) begin
        gnt1_s = 1'b1;
      end else begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
      end
    end else begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end
  end

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (gnt0_s || gnt1_s) begin
          state_next_s = EXEC;
        end else begin
          state_next_s = IDLE;
        end
      end
      EXEC: state_next_s = RESP;
      RESP: begin
        if (rsp_ready_i) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = RESP;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Operand latch on grant, result/carry capture at the end of EXEC
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      last_id_r <= 1'b1;
      op_r      <= 2'b00;
      a_r       <= '0;
      b_r       <= '0;
      id_r      <= 1'b0;
      result_r  <= '0;
      carry_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (gnt0_s || gnt1_s) begin
            op_r      <= gnt1_s ? req1_op_i : req0_op_i;
            a_r       <= gnt1_s ? req1_a_i  : req0_a_i;
            b_r       <= gnt1_s ? req1_b_i  : req0_b_i;
            id_r      <= gnt1_s;
            last_id_r <= gnt1_s;
          end
        end
        EXEC: begin
          result_r <= alu_result_i;
          // op[1] set means ADD/SUB; logical ops never report a carry
          carry_r  <= op_r[1] & alu_carry_i;
        end
        default: begin
          result_r <= result_r;
        end
      endcase
    end
  end

  assign req0_ready_o  = gnt0_s;
  assign req1_ready_o  = gnt1_s;
  assign rsp_valid_o   = (state_r == RESP);
  assign rsp_result_o  = result_r;
  assign rsp_carry_o   = carry_r;
  assign rsp_id_o      = id_r;
  assign alu_control_o = op_r;
  assign alu_a_o       = a_r;
  assign alu_b_o       = b_r;
  assign busy_o        = (state_r != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: reset values, directed vector table,
// contention, back-pressure, reset mid-op, idle hold, and a randomized run
// checked against an arithmetic reference model.
module tb_alu_arbiter;
  localparam int N = 64;

  logic         clk_i = 1'b0;
  logic         rst_n_i;
  logic         req0_valid_i, req0_ready_o;
  logic [1:0]   req0_op_i;
  logic [N-1:0] req0_a_i, req0_b_i;
  logic         req1_valid_i, req1_ready_o;
  logic [1:0]   req1_op_i;
  logic [N-1:0] req1_a_i, req1_b_i;
  logic         rsp_valid_o, rsp_ready_i;
  logic [N-1:0] rsp_result_o;
  logic         rsp_carry_o, rsp_id_o;
  logic [1:0]   alu_control_o;
  logic [N-1:0] alu_a_o, alu_b_o;
  logic [N-1:0] alu_result_i;
  logic         alu_carry_i;
  logic         busy_o;
  logic         force_c;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  alu_arbiter #(.N(N)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o), .req0_op_i(req0_op_i),
    .req0_a_i(req0_a_i), .req0_b_i(req0_b_i),
    .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o), .req1_op_i(req1_op_i),
    .req1_a_i(req1_a_i), .req1_b_i(req1_b_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_result_o(rsp_result_o),
    .rsp_carry_o(rsp_carry_o), .rsp_id_o(rsp_id_o),
    .alu_control_o(alu_control_o), .alu_a_o(alu_a_o), .alu_b_o(alu_b_o),
    .alu_result_i(alu_result_i), .alu_carry_i(alu_carry_i), .busy_o(busy_o)
  );

  // Combinational ALU stand-in; force_c pins carry high for AND/OR only
  logic [N:0] sum_s;
  always_comb begin
    sum_s        = '0;
    alu_result_i = '0;
    alu_carry_i  = 1'b0;
    case (alu_control_o)
      2'b00: alu_result_i = alu_a_o & alu_b_o;
      2'b01: alu_result_i = alu_a_o | alu_b_o;
      2'b10: begin
        sum_s = {1'b0, alu_a_o} + {1'b0, alu_b_o};
        alu_result_i = sum_s[N-1:0];
        alu_carry_i  = sum_s[N];
      end
      default: begin
        sum_s = {1'b0, alu_a_o} + {1'b0, ~alu_b_o} + {{N{1'b0}}, 1'b1};
        alu_result_i = sum_s[N-1:0];
        alu_carry_i  = sum_s[N];
      end
    endcase
    if (force_c && !alu_control_o[1]) alu_carry_i = 1'b1;
  end

  task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Reference: results straight from the operation definitions
  function automatic void ref_op(input logic [1:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                                 output logic [N-1:0] r, output logic c);
    case (op)
      2'b00: begin r = a & b; c = 1'b0; end
      2'b01: begin r = a | b; c = 1'b0; end
      2'b10: begin r = a + b; c = ({1'b0, a} + {1'b0, b}) > {1'b0, {N{1'b1}}}; end
      default: begin r = a - b; c = (a >= b); end
    endcase
  endfunction

  task automatic chk_zero(input string nm);
    chk({nm, "_rdy0"}, req0_ready_o, 0);
    chk({nm, "_rdy1"}, req1_ready_o, 0);
    chk({nm, "_rvalid"}, rsp_valid_o, 0);
    chk({nm, "_result"}, rsp_result_o, 0);
    chk({nm, "_carry"}, rsp_carry_o, 0);
    chk({nm, "_id"}, rsp_id_o, 0);
    chk({nm, "_ctl"}, alu_control_o, 0);
    chk({nm, "_a"}, alu_a_o, 0);
    chk({nm, "_b"}, alu_b_o, 0);
    chk({nm, "_busy"}, busy_o, 0);
  endtask

  task automatic wait_gnt(output logic g0, output logic g1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      if (req0_ready_o || req1_ready_o) break;
    end
    g0 = req0_ready_o;
    g1 = req1_ready_o;
  endtask

  // Single-requester op with rsp_ready_i high; checks exact cycle timing
  task automatic do_op(input logic rid, input logic [1:0] op, input logic [N-1:0] a,
                       input logic [N-1:0] b, input logic [N-1:0] er, input logic ec);
    logic g0, g1;
    @(posedge clk_i); #1;
    if (rid) begin
      req1_op_i = op; req1_a_i = a; req1_b_i = b; req1_valid_i = 1'b1;
    end else begin
      req0_op_i = op; req0_a_i = a; req0_b_i = b; req0_valid_i = 1'b1;
    end
    wait_gnt(g0, g1);
    chk("op_ready_own", rid ? g1 : g0, 1);
    chk("op_ready_other", rid ? g0 : g1, 0);
    @(posedge clk_i); #1;
    req0_valid_i = 1'b0; req1_valid_i = 1'b0;
    @(negedge clk_i);
    chk("exec_ctl", alu_control_o, op);
    chk("exec_a", alu_a_o, a);
    chk("exec_b", alu_b_o, b);
    chk("exec_busy", busy_o, 1);
    chk("exec_rvalid", rsp_valid_o, 0);
    @(negedge clk_i);
    chk("resp_valid", rsp_valid_o, 1);
    chk("resp_result", rsp_result_o, er);
    chk("resp_carry", rsp_carry_o, ec);
    chk("resp_id", rsp_id_o, rid);
    @(negedge clk_i);
    chk("after_busy", busy_o, 0);
    chk("after_rvalid", rsp_valid_o, 0);
  endtask

  task automatic do_reset();
    rst_n_i = 1'b0;
    #1;
    chk_zero("rst");
    @(negedge clk_i);
    rst_n_i = 1'b1;
  endtask

  typedef struct {
    logic         rid;
    logic [1:0]   op;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         fc;
    logic [N-1:0] er;
    logic         ec;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic g0, g1, eg, ec, done;
    logic [3:0] exp_g;
    logic [1:0] pend;
    logic [1:0] p_op[2];
    logic [N-1:0] p_a[2], p_b[2], er, hold_r;
    logic m_last;

    vecs[0] = '{1'b0, 2'b10, 64'd5, 64'd3, 1'b0, 64'd8, 1'b0};
    vecs[1] = '{1'b1, 2'b10, {N{1'b1}}, 64'd1, 1'b0, 64'd0, 1'b1};
    vecs[2] = '{1'b0, 2'b11, 64'd3, 64'd5, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0};
    vecs[3] = '{1'b1, 2'b00, {N{1'b1}}, 64'hF0, 1'b1, 64'hF0, 1'b0};
    vecs[4] = '{1'b0, 2'b01, 64'h0F00, 64'h00F0, 1'b1, 64'h0FF0, 1'b0};
    vecs[5] = '{1'b1, 2'b11, 64'd5, 64'd3, 1'b0, 64'd2, 1'b1};

    req0_valid_i = 1'b0; req0_op_i = 2'b00; req0_a_i = '0; req0_b_i = '0;
    req1_valid_i = 1'b0; req1_op_i = 2'b00; req1_a_i = '0; req1_b_i = '0;
    rsp_ready_i = 1'b1; force_c = 1'b0;
    rst_n_i = 1'b1;
    #3;
    do_reset();

    // Contention straight out of reset: last_id = 1, requester 0 first
`ifdef ALU_ARB_FIXED_PRIO_EN
    exp_g = 4'b0000;
`else
    exp_g = 4'b1010;
`endif
    @(posedge clk_i); #1;
    req0_op_i = 2'b10; req0_a_i = 64'd10; req0_b_i = 64'd1; req0_valid_i = 1'b1;
    req1_op_i = 2'b10; req1_a_i = 64'd20; req1_b_i = 64'd2; req1_valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_gnt(g0, g1);
      chk("cont_grant", g1, exp_g[i]);
      chk("cont_one_hot", g0 ^ g1, 1);
      @(negedge clk_i);
      @(negedge clk_i);
      chk("cont_rvalid", rsp_valid_o, 1);
      chk("cont_id", rsp_id_o, exp_g[i]);
      chk("cont_result", rsp_result_o, exp_g[i] ? 64'd22 : 64'd11);
    end
    req0_valid_i = 1'b0; req1_valid_i = 1'b0;

    // Directed vector table
    for (int i = 0; i < 6; i++) begin
      force_c = vecs[i].fc;
      do_op(vecs[i].rid, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].er, vecs[i].ec);
    end
    force_c = 1'b0;

    // Back-pressure: response held for 5 cycles, no grants meanwhile
    rsp_ready_i = 1'b0;
    @(posedge clk_i); #1;
    req0_op_i = 2'b01; req0_a_i = 64'hA000; req0_b_i = 64'h000B; req0_valid_i = 1'b1;
    wait_gnt(g0, g1);
    chk("bp_grant", g0, 1);
    @(posedge clk_i); #1;
    req0_valid_i = 1'b0;
    req1_op_i = 2'b10; req1_a_i = 64'd1; req1_b_i = 64'd1; req1_valid_i = 1'b1;
    @(negedge clk_i);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      chk("bp_rvalid", rsp_valid_o, 1);
      chk("bp_result", rsp_result_o, 64'hA00B);
      chk("bp_carry", rsp_carry_o, 0);
      chk("bp_id", rsp_id_o, 0);
      chk("bp_rdy0", req0_ready_o, 0);
      chk("bp_rdy1", req1_ready_o, 0);
      chk("bp_busy", busy_o, 1);
    end
    req1_valid_i = 1'b0;
    rsp_ready_i = 1'b1;
    @(negedge clk_i);
    chk("bp_release_busy", busy_o, 0);
    chk("bp_release_rvalid", rsp_valid_o, 0);

    // Reset in the middle of EXEC, then a clean op
    @(posedge clk_i); #1;
    req0_op_i = 2'b10; req0_a_i = 64'd7; req0_b_i = 64'd9; req0_valid_i = 1'b1;
    wait_gnt(g0, g1);
    chk("mid_grant", g0, 1);
    @(posedge clk_i); #1;
    req0_valid_i = 1'b0;
    #2;
    chk("mid_busy_pre", busy_o, 1);
    do_reset();
    do_op(1'b0, 2'b10, 64'd100, 64'd23, 64'd123, 1'b0);

    // Idle: nothing valid, ALU drive holds the last op
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      chk("idle_busy", busy_o, 0);
      chk("idle_rdy", req0_ready_o | req1_ready_o, 0);
      chk("idle_rvalid", rsp_valid_o, 0);
      chk("idle_ctl", alu_control_o, 2'b10);
      chk("idle_a", alu_a_o, 64'd100);
      chk("idle_b", alu_b_o, 64'd23);
    end

    // Randomized traffic against the reference model
    do_reset();
    m_last = 1'b1;
    pend = 2'b00;
    for (int r = 0; r < 60; r++) begin
      @(posedge clk_i); #1;
      for (int k = 0; k < 2; k++) begin
        if (!pend[k] && ($urandom_range(0, 1) == 1)) begin
          pend[k] = 1'b1;
          p_op[k] = 2'($urandom_range(0, 3));
          p_a[k]  = {$urandom, $urandom};
          p_b[k]  = ($urandom_range(0, 3) == 0) ? p_a[k] : {$urandom, $urandom};
        end
      end
      if (pend == 2'b00) begin
        pend[0] = 1'b1; p_op[0] = 2'b11; p_a[0] = {$urandom, $urandom}; p_b[0] = {$urandom, $urandom};
      end
      force_c = 1'($urandom_range(0, 1));
      req0_valid_i = pend[0]; req0_op_i = p_op[0]; req0_a_i = p_a[0]; req0_b_i = p_b[0];
      req1_valid_i = pend[1]; req1_op_i = p_op[1]; req1_a_i = p_a[1]; req1_b_i = p_b[1];
`ifdef ALU_ARB_FIXED_PRIO_EN
      eg = (pend == 2'b11) ? 1'b0 : pend[1];
`else
      eg = (pend == 2'b11) ? ~m_last : pend[1];
`endif
      wait_gnt(g0, g1);
      chk("rand_grant1", g1, eg);
      chk("rand_grant0", g0, !eg);
      ref_op(p_op[eg], p_a[eg], p_b[eg], er, ec);
      m_last = eg;
      @(posedge clk_i); #1;
      pend[eg] = 1'b0;
      req0_valid_i = pend[0];
      req1_valid_i = pend[1];
      rsp_ready_i = 1'($urandom_range(0, 1));
      done = 1'b0;
      hold_r = er;
      for (int c = 0; c < 30 && !done; c++) begin
        @(negedge clk_i);
        chk("rand_rdy_blocked", req0_ready_o | req1_ready_o, 0);
        if (rsp_valid_o) begin
          chk("rand_result", rsp_result_o, hold_r);
          chk("rand_carry", rsp_carry_o, ec);
          chk("rand_id", rsp_id_o, eg);
          if (rsp_ready_i) done = 1'b1;
        end
        if (!done) begin
          @(posedge clk_i); #1;
          rsp_ready_i = 1'($urandom_range(0, 1));
        end
      end
      chk("rand_done", done, 1);
    end
    @(posedge clk_i); #1;
    req0_valid_i = 1'b0; req1_valid_i = 1'b0; rsp_ready_i = 1'b1;
    @(negedge clk_i);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
